// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: latches a word, drives the bit serializer and
// frames the line as start bit, data bits LSB first, optional parity, stop bit.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Ser_Data,
  input  logic                  Ser_Done,
  output logic [DATA_WIDTH-1:0] Ser_P_DATA,
  output logic                  Ser_En,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Sync_Err
);

  localparam int CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  parEn_q;
  logic                  parity_q;
  logic                  busy_q;
  logic                  syncErr_q;
  logic [CntW-1:0]       bitCnt_q;

  logic                  parity_d;
  logic [CntW-1:0]       bitCnt_d;
  logic                  lastBit;
  logic                  dataExit;

  assign parity_d = (^P_DATA) ^ PAR_TYP;
  assign bitCnt_d = bitCnt_q + CntW'(1);
  assign lastBit  = (bitCnt_q == LastIdx);
  // Either the serializer's done flag or our own count ends the data phase;
  // a disagreement between them is reported but never stalls the frame.
  assign dataExit = Ser_Done | lastBit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      word_q    <= '0;
      parEn_q   <= 1'b0;
      parity_q  <= 1'b0;
      busy_q    <= 1'b0;
      syncErr_q <= 1'b0;
      bitCnt_q  <= '0;
    end else begin
      syncErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (DATA_VALID) begin
            word_q   <= P_DATA;
            parEn_q  <= PAR_EN;
            parity_q <= parity_d;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          bitCnt_q <= '0;
          state_q  <= DATA;
        end
        DATA: begin
          bitCnt_q <= bitCnt_d;
          if (dataExit) begin
            syncErr_q <= Ser_Done ^ lastBit;
            state_q   <= parEn_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          state_q <= STOP;
        end
        STOP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Line mux uses only registered sources: state, latched parity and the
  // serializer's registered data bit.
  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = Ser_Data;
      PARITY:  TX_OUT = parity_q;
      default: TX_OUT = 1'b1;
    endcase
  end

  assign Ser_En     = (state_q == START) || ((state_q == DATA) && !Ser_Done);
  assign Ser_P_DATA = word_q;
  assign Busy       = busy_q;
  assign Sync_Err   = syncErr_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm with a behavioural serializer and a
// frame-level reference model built from the word, parity mode and options.
module tb_uart_tx_fsm;

  localparam int W = 8;
  localparam int IdxW = $clog2(W);

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         Ser_Data;
  logic         Ser_Done;
  logic [W-1:0] Ser_P_DATA;
  logic         Ser_En;
  logic         TX_OUT;
  logic         Busy;
  logic         Sync_Err;

  int checks = 0;
  int passes = 0;
  bit earlyMode = 1'b0;
  logic [IdxW-1:0] serIdx;

  uart_tx_fsm #(.DATA_WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .Ser_Data(Ser_Data),
    .Ser_Done(Ser_Done),
    .Ser_P_DATA(Ser_P_DATA),
    .Ser_En(Ser_En),
    .TX_OUT(TX_OUT),
    .Busy(Busy),
    .Sync_Err(Sync_Err)
  );

  always #5 CLK = ~CLK;

  // Serializer model: presents one bit per enabled cycle, one cycle later,
  // and raises done with the last bit (or one bit early in earlyMode).
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      serIdx   <= '0;
      Ser_Data <= 1'b0;
      Ser_Done <= 1'b0;
    end else if (Ser_En) begin
      Ser_Data <= Ser_P_DATA[serIdx];
      Ser_Done <= (serIdx == (earlyMode ? IdxW'(W - 2) : IdxW'(W - 1)));
      serIdx   <= serIdx + IdxW'(1);
    end else begin
      serIdx   <= '0;
      Ser_Done <= 1'b0;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Present a request on a falling edge so it is accepted on the next rising edge.
  task automatic applyStimulus(input logic [W-1:0] word, input logic parEn, input logic parTyp);
    @(negedge CLK);
    P_DATA     = word;
    PAR_EN     = parEn;
    PAR_TYP    = parTyp;
    DATA_VALID = 1'b1;
    @(posedge CLK);
  endtask

  task automatic runFrame(input logic [W-1:0] word, input logic parEn, input logic parTyp,
                          input bit early, input bit noise, input string name);
    bit expBits[$];
    int ones;
    int nData;
    int busyCnt;
    int enCnt;
    int errCnt;
    ones    = 0;
    busyCnt = 0;
    enCnt   = 0;
    errCnt  = 0;
    nData   = early ? W - 1 : W;
    for (int i = 0; i < W; i++) ones += int'(word[i]);
    expBits.push_back(1'b0);
    for (int i = 0; i < nData; i++) expBits.push_back(word[i]);
    if (parEn) expBits.push_back(bit'(ones % 2) ^ parTyp);
    expBits.push_back(1'b1);
    earlyMode = early;
    applyStimulus(word, parEn, parTyp);
    for (int k = 0; k < expBits.size(); k++) begin
      @(negedge CLK);
      checkOutput($sformatf("%s bit%0d", name, k), 32'(TX_OUT), 32'(expBits[k]));
      busyCnt += int'(Busy);
      enCnt   += int'(Ser_En);
      errCnt  += int'(Sync_Err);
      if (k == 0) checkOutput($sformatf("%s latched", name), 32'(Ser_P_DATA), 32'(word));
      if (noise) begin
        P_DATA     = W'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        DATA_VALID = (k == expBits.size() - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        DATA_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    errCnt += int'(Sync_Err);
    checkOutput($sformatf("%s idle line", name), 32'(TX_OUT), 32'd1);
    checkOutput($sformatf("%s idle busy", name), 32'(Busy), 32'd0);
    checkOutput($sformatf("%s busy cycles", name), 32'(busyCnt), 32'(expBits.size()));
    checkOutput($sformatf("%s enable cycles", name), 32'(enCnt), 32'(nData));
    checkOutput($sformatf("%s sync err pulses", name), 32'(errCnt), early ? 32'd1 : 32'd0);
    checkOutput($sformatf("%s word held", name), 32'(Ser_P_DATA), 32'(word));
    @(negedge CLK);
    checkOutput($sformatf("%s no queued frame", name), 32'(Busy), 32'd0);
    earlyMode = 1'b0;
  endtask

  // Reset during the given data bit must drop the frame at once.
  task automatic abortFrame(input logic [W-1:0] word, input int dataBit);
    applyStimulus(word, 1'b1, 1'b0);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (dataBit) @(negedge CLK);
    checkOutput("abort pre busy", 32'(Busy), 32'd1);
    #1 RST = 1'b1;
    #1;
    checkOutput("abort line", 32'(TX_OUT), 32'd1);
    checkOutput("abort busy", 32'(Busy), 32'd0);
    checkOutput("abort enable", 32'(Ser_En), 32'd0);
    checkOutput("abort word", 32'(Ser_P_DATA), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("abort after idle", 32'(TX_OUT), 32'd1);
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset line", 32'(TX_OUT), 32'd1);
    checkOutput("reset busy", 32'(Busy), 32'd0);
    checkOutput("reset enable", 32'(Ser_En), 32'd0);
    checkOutput("reset sync err", 32'(Sync_Err), 32'd0);
    checkOutput("reset word", 32'(Ser_P_DATA), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("idle%0d line", i), 32'(TX_OUT), 32'd1);
      checkOutput($sformatf("idle%0d busy", i), 32'(Busy), 32'd0);
      checkOutput($sformatf("idle%0d enable", i), 32'(Ser_En), 32'd0);
    end

    runFrame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "a5_even");
    runFrame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, "01_odd");
    runFrame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, "01_even");
    runFrame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "ff_nopar");
    runFrame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, "3c_noise");
    abortFrame(8'h96, 4);
    runFrame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, "55_after_abort");
    runFrame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, "early_par");
    runFrame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, "early_nopar");

    for (int n = 0; n < 20; n++) begin
      runFrame(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               1'($urandom), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
